// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN convolution control path: address-generator
// select codes, sequencer state encoding and default pass geometry.
package cnn_pkg;

    localparam int unsigned ADDR_W       = 7;
    localparam int unsigned DEF_FILT_LEN = 4;
    localparam int unsigned DEF_WIN_LEN  = 16;
    localparam int unsigned DEF_MAX_OUT  = 64;

    localparam logic [1:0] SEL_X    = 2'b00;
    localparam logic [1:0] SEL_Y    = 2'b01;
    localparam logic [1:0] SEL_Z    = 2'b10;
    localparam logic [1:0] SEL_IDLE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_FETCH_Y = 3'd2,
        ST_FETCH_X = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_WRITE_Z = 3'd5,
        ST_CHECK   = 3'd6,
        ST_FIN     = 3'd7
    } seq_state_e;

endpackage

// File: rtl/seq_counter.sv
// Saturating up-counter with clear, load and enable; flags when the count
// equals TC_VAL. Saturation at LIMIT keeps it from wrapping within a pass.
module seq_counter #(
    parameter int unsigned LIMIT  = 4,
    parameter int unsigned TC_VAL = LIMIT,
    parameter int unsigned W      = $clog2(LIMIT + 1)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_ld,
    input  logic [W-1:0] i_ld_val,
    input  logic         i_en,
    output logic         o_tc_c
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_ld) begin
            r_cnt <= i_ld_val;
        end else if (i_en && (r_cnt != W'(LIMIT))) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_tc_c = (r_cnt == W'(TC_VAL));

endmodule

// File: rtl/conv_sequencer.sv
// Convolution pass controller: loads the filter once, then loops window fetch,
// accumulate and result write until the address generator or MAX_OUT ends it.
module conv_sequencer
    import cnn_pkg::*;
#(
    parameter int unsigned FILT_LEN = DEF_FILT_LEN,
    parameter int unsigned WIN_LEN  = DEF_WIN_LEN,
    parameter int unsigned MAX_OUT  = DEF_MAX_OUT
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_mem_ready,
    input  logic       i_done_adr,
    output logic       o_ag_ld,
    output logic       o_ag_rst_x_c,
    output logic [1:0] o_ag_sel_c,
    output logic       o_mem_rd_c,
    output logic       o_mem_wr_c,
    output logic       o_filt_ld,
    output logic       o_mac_clr_c,
    output logic       o_mac_en,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err_flag
);

    seq_state_e r_state;
    seq_state_e w_next;

    logic [1:0] w_sel;
    logic       w_rd;
    logic       w_wr;
    logic       w_rst_x;
    logic       w_mac_clr;
    logic       w_filt_acc;
    logic       w_win_acc;
    logic       w_out_acc;
    logic       w_win_clr;
    logic       w_set_err;
    logic       w_accept_start;
    logic       w_filt_last;
    logic       w_win_last;
    logic       w_out_tc;

    logic r_ag_ld;
    logic r_filt_ld;
    logic r_mac_en;
    logic r_busy;
    logic r_done;
    logic r_err;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and access strobes; a refused access leaves everything parked
    always_comb begin
        w_next         = r_state;
        w_sel          = SEL_IDLE;
        w_rd           = 1'b0;
        w_wr           = 1'b0;
        w_rst_x        = 1'b0;
        w_mac_clr      = 1'b0;
        w_filt_acc     = 1'b0;
        w_win_acc      = 1'b0;
        w_out_acc      = 1'b0;
        w_win_clr      = 1'b0;
        w_set_err      = 1'b0;
        w_accept_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_accept_start = 1'b1;
                    w_next         = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_mac_clr = 1'b1;
                w_next    = ST_FETCH_Y;
            end
            ST_FETCH_Y: begin
                if (i_mem_ready) begin
                    w_sel      = SEL_Y;
                    w_rd       = 1'b1;
                    w_filt_acc = 1'b1;
                    if (w_filt_last) begin
                        w_next = ST_FETCH_X;
                    end
                end
            end
            ST_FETCH_X: begin
                if (i_mem_ready) begin
                    w_sel     = SEL_X;
                    w_rd      = 1'b1;
                    w_win_acc = 1'b1;
                    if (w_win_last) begin
                        w_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                w_next = ST_WRITE_Z;
            end
            ST_WRITE_Z: begin
                if (i_mem_ready) begin
                    w_sel     = SEL_Z;
                    w_wr      = 1'b1;
                    w_out_acc = 1'b1;
                    w_next    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // Address-generator completion outranks the safety limit
                if (i_done_adr) begin
                    w_next = ST_FIN;
                end else if (w_out_tc) begin
                    w_set_err = 1'b1;
                    w_next    = ST_FIN;
                end else begin
                    w_rst_x   = 1'b1;
                    w_mac_clr = 1'b1;
                    w_win_clr = 1'b1;
                    w_next    = ST_FETCH_X;
                end
            end
            ST_FIN: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Registered status and delayed capture strobes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ag_ld   <= 1'b0;
            r_filt_ld <= 1'b0;
            r_mac_en  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_ag_ld   <= (w_next == ST_LOAD);
            r_filt_ld <= w_filt_acc;
            r_mac_en  <= w_win_acc;
            r_busy    <= (w_next != ST_IDLE);
            r_done    <= (w_next == ST_FIN);
            if (w_accept_start) begin
                r_err <= 1'b0;
            end else if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    seq_counter #(
        .LIMIT  (FILT_LEN),
        .TC_VAL (FILT_LEN - 1)
    ) u_filt_cnt (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (w_accept_start),
        .i_ld     (1'b0),
        .i_ld_val ('0),
        .i_en     (w_filt_acc),
        .o_tc_c   (w_filt_last)
    );

    seq_counter #(
        .LIMIT  (WIN_LEN),
        .TC_VAL (WIN_LEN - 1)
    ) u_win_cnt (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (w_accept_start),
        .i_ld     (w_win_clr),
        .i_ld_val ('0),
        .i_en     (w_win_acc),
        .o_tc_c   (w_win_last)
    );

    seq_counter #(
        .LIMIT  (MAX_OUT),
        .TC_VAL (MAX_OUT)
    ) u_out_cnt (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (w_accept_start),
        .i_ld     (1'b0),
        .i_ld_val ('0),
        .i_en     (w_out_acc),
        .o_tc_c   (w_out_tc)
    );

    assign o_ag_ld      = r_ag_ld;
    assign o_ag_rst_x_c = w_rst_x;
    assign o_ag_sel_c   = w_sel;
    assign o_mem_rd_c   = w_rd;
    assign o_mem_wr_c   = w_wr;
    assign o_filt_ld    = r_filt_ld;
    assign o_mac_clr_c  = w_mac_clr;
    assign o_mac_en     = r_mac_en;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err_flag   = r_err;

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: directed timing, reset, stall and limit passes plus
// randomized passes scored against per-pass transaction totals.
module tb_conv_sequencer;
    import cnn_pkg::*;

    localparam int FL   = 4;
    localparam int WL   = 16;
    localparam int MO_B = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic mem_ready = 1'b1;
    logic done_adr_a = 1'b0;
    logic done_adr_b = 1'b0;

    logic       a_ag_ld, a_rst_x, a_mem_rd, a_mem_wr, a_filt_ld, a_mac_clr, a_mac_en, a_busy, a_done, a_err;
    logic [1:0] a_sel;
    logic       b_ag_ld, b_rst_x, b_mem_rd, b_mem_wr, b_filt_ld, b_mac_clr, b_mac_en, b_busy, b_done, b_err;
    logic [1:0] b_sel;

    int checks = 0;
    int errors = 0;

    int n_y, n_x, n_wr, n_done, n_rstx, n_ld, n_stall_bad, n_seq_bad, cyc;
    int t_filt_first, t_filt_last, t_mac_first, t_mac_last, t_wr_last, t_done, t_ld;
    int nb_wr, nb_done;
    int tgt_a = 1000;
    int tgt_b = 1000;
    int stall_mode = 0;
    bit b_adr_en = 1'b0;
    logic prev_y = 1'b0;
    logic prev_x = 1'b0;
    logic y_acc, x_acc;

    conv_sequencer u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_mem_ready(mem_ready),
        .i_done_adr(done_adr_a), .o_ag_ld(a_ag_ld), .o_ag_rst_x_c(a_rst_x), .o_ag_sel_c(a_sel),
        .o_mem_rd_c(a_mem_rd), .o_mem_wr_c(a_mem_wr), .o_filt_ld(a_filt_ld), .o_mac_clr_c(a_mac_clr),
        .o_mac_en(a_mac_en), .o_busy(a_busy), .o_done(a_done), .o_err_flag(a_err)
    );

    conv_sequencer #(.MAX_OUT(MO_B)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_mem_ready(mem_ready),
        .i_done_adr(done_adr_b), .o_ag_ld(b_ag_ld), .o_ag_rst_x_c(b_rst_x), .o_ag_sel_c(b_sel),
        .o_mem_rd_c(b_mem_rd), .o_mem_wr_c(b_mem_wr), .o_filt_ld(b_filt_ld), .o_mac_clr_c(b_mac_clr),
        .o_mac_en(b_mac_en), .o_busy(b_busy), .o_done(b_done), .o_err_flag(b_err)
    );

    always #5 clk = ~clk;

    // Transaction observer for DUT A; cycle 0 is the cycle start is sampled in IDLE
    always @(negedge clk) begin
        y_acc = a_mem_rd && mem_ready && (a_sel == SEL_Y);
        x_acc = a_mem_rd && mem_ready && (a_sel == SEL_X);
        if (start_a && !a_busy) cyc = 0;
        else cyc++;
        if (!mem_ready && (a_sel != SEL_IDLE || a_mem_rd || a_mem_wr)) n_stall_bad++;
        if (a_mem_rd && !(a_sel == SEL_X || a_sel == SEL_Y)) n_stall_bad++;
        if (a_mem_wr && a_sel != SEL_Z) n_stall_bad++;
        if (a_filt_ld !== prev_y || a_mac_en !== prev_x) n_seq_bad++;
        prev_y = y_acc;
        prev_x = x_acc;
        if (y_acc) n_y++;
        if (x_acc) n_x++;
        if (a_filt_ld) begin
            if (t_filt_first < 0) t_filt_first = cyc;
            t_filt_last = cyc;
        end
        if (a_mac_en) begin
            if (t_mac_first < 0) t_mac_first = cyc;
            t_mac_last = cyc;
        end
        if (a_mem_wr && mem_ready) begin
            n_wr++;
            t_wr_last = cyc;
        end
        if (a_done) begin
            n_done++;
            t_done = cyc;
        end
        if (a_rst_x) n_rstx++;
        if (a_ag_ld) begin
            n_ld++;
            t_ld = cyc;
        end
        if (b_mem_wr && mem_ready) nb_wr++;
        if (b_done) nb_done++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        n_y = 0; n_x = 0; n_wr = 0; n_done = 0; n_rstx = 0; n_ld = 0;
        n_stall_bad = 0; n_seq_bad = 0; nb_wr = 0; nb_done = 0;
        t_filt_first = -1; t_filt_last = -1; t_mac_first = -1; t_mac_last = -1;
        t_wr_last = -1; t_done = -1; t_ld = -1;
    endtask

    // One clock, then drive stimulus for the next cycle away from the edge
    task automatic step();
        @(posedge clk);
        #1;
        case (stall_mode)
            0:       mem_ready = 1'b1;
            1:       mem_ready = ~mem_ready;
            default: mem_ready = 1'($urandom_range(0, 1));
        endcase
        done_adr_a = (n_wr >= tgt_a);
        done_adr_b = b_adr_en && (nb_wr >= tgt_b);
    endtask

    task automatic run_pass_a(input int tgt, input int mode, input int poke);
        clr_mon();
        tgt_a = tgt;
        stall_mode = mode;
        done_adr_a = 1'b0;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int i = 0; i < 4000 && n_done == 0; i++) begin
            start_a = (i == poke);
            step();
        end
        start_a = 1'b0;
        step();
        step();
        chk("a_done_count", n_done, 1);
        tgt_a = 1000;
    endtask

    // Expected totals follow from the pass rules: one filter load, WIN_LEN
    // reads and one write per window, an x-reset between windows
    task automatic chk_totals(input string tag, input int writes);
        chk({tag, "_y_reads"}, n_y, FL);
        chk({tag, "_x_reads"}, n_x, WL * writes);
        chk({tag, "_writes"}, n_wr, writes);
        chk({tag, "_rst_x"}, n_rstx, writes - 1);
        chk({tag, "_stall_rule"}, n_stall_bad, 0);
        chk({tag, "_strobe_delay"}, n_seq_bad, 0);
        chk({tag, "_err"}, a_err, 0);
        chk({tag, "_busy_after"}, a_busy, 0);
    endtask

    task automatic run_pass_b(input bit adr_en, input int tgt);
        clr_mon();
        b_adr_en = adr_en;
        tgt_b = tgt;
        stall_mode = 2;
        done_adr_b = 1'b0;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        chk("b_err_cleared_on_start", b_err, 0);
        for (int i = 0; i < 4000 && nb_done == 0; i++) step();
        step();
        chk("b_done_count", nb_done, 1);
        b_adr_en = 1'b0;
    endtask

    initial begin
        int tgt;
        clr_mon();
        #1;
        chk("rst_sel", a_sel, SEL_IDLE);
        chk("rst_busy", a_busy, 0);
        chk("rst_err", a_err, 0);
        chk("rst_done", a_done, 0);
        chk("rst_mem_rd", a_mem_rd, 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single window, no stalls: exact cycle positions
        run_pass_a(1, 0, -1);
        chk("t1_ag_ld", t_ld, 1);
        chk("t1_filt_first", t_filt_first, 3);
        chk("t1_filt_last", t_filt_last, 6);
        chk("t1_mac_first", t_mac_first, 7);
        chk("t1_mac_last", t_mac_last, 22);
        chk("t1_write", t_wr_last, 23);
        chk("t1_done", t_done, 25);
        chk_totals("t1", 1);

        // Two windows: second window 19 cycles later
        run_pass_a(2, 0, -1);
        chk("t2_write", t_wr_last, 42);
        chk("t2_done", t_done, 44);
        chk_totals("t2", 2);

        // Reset in FETCH_X aborts at once with no write
        clr_mon();
        tgt_a = 1;
        stall_mode = 0;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int i = 0; i < 9; i++) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sel", a_sel, SEL_IDLE);
        chk("mid_rst_rd", a_mem_rd, 0);
        chk("mid_rst_wr", a_mem_wr, 0);
        chk("mid_rst_busy", a_busy, 0);
        chk("mid_rst_mac_en", a_mac_en, 0);
        chk("mid_rst_filt_ld", a_filt_ld, 0);
        step();
        step();
        chk("mid_rst_no_write", n_wr, 0);
        rst_n = 1'b1;
        step();
        run_pass_a(1, 0, -1);
        chk("after_rst_ag_ld", t_ld, 1);
        chk("after_rst_done", t_done, 25);
        chk_totals("after_rst", 1);

        // Alternating stalls
        run_pass_a(1, 1, -1);
        chk_totals("alt1", 1);
        run_pass_a(2, 1, -1);
        chk_totals("alt2", 2);

        // Three windows
        run_pass_a(3, 0, -1);
        chk_totals("three", 3);

        // Random stall patterns and window counts
        for (int p = 0; p < 5; p++) begin
            tgt = int'($urandom_range(1, 4));
            run_pass_a(tgt, 2, -1);
            chk_totals("rand", tgt);
        end

        // Start while busy is ignored
        run_pass_a(1, 0, 9);
        chk("busy_start_loads", n_ld, 1);
        chk("busy_start_done", t_done, 25);
        chk_totals("busy_start", 1);

        // Safety limit on the MAX_OUT=2 instance
        run_pass_b(1'b0, 0);
        chk("lim_writes", nb_wr, MO_B);
        chk("lim_err", b_err, 1);
        step();
        step();
        chk("lim_err_sticky", b_err, 1);
        run_pass_b(1'b1, MO_B);
        chk("prio_writes", nb_wr, MO_B);
        chk("prio_err", b_err, 0);
        run_pass_b(1'b1, 1);
        chk("early_writes", nb_wr, 1);
        chk("early_err", b_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_sequencer.md
Name: conv_sequencer

Overview:
- Top-level controller for the CNN convolution datapath.
- Drives the address generator: base load, select, row-counter reset. Drives memory read/write strobes and MAC accumulator controls.
- Runs a full convolution pass from a single start pulse: fetch filter once, then repeatedly fetch window, accumulate, write result.
- Ends when the address generator asserts doneAdr, or when an output-count safety limit is reached.

Parameters:
- ADDR_W, 7, width of base addresses passed to the address generator.
- FILT_LEN, 4, filter words fetched once per pass (sel=01 steps).
- WIN_LEN, 16, input words fetched per output window (sel=00 steps).
- MAX_OUT, 64, safety limit on outputs written; reaching it aborts with errFlag.

Ports:
- clk  in  1  rising-edge clock
- rstN  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a pass; sampled in IDLE only
- memReady  in  1  memory accepts the access offered this cycle
- doneAdr  in  1  row-complete flag from the address generator
- agLd  out  1  address generator base load
- agRstX  out  1  address generator x-counter reset
- agSel  out  2  00=x, 01=y, 10=z, 11=idle (no advance)
- memRd  out  1  read strobe
- memWr  out  1  write strobe
- filtLd  out  1  capture filter word (one cycle after a filter read)
- macClr  out  1  clear accumulator
- macEn  out  1  accumulate input word (one cycle after an x read)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- errFlag  out  1  set when MAX_OUT is hit; cleared by the next accepted start

Behaviour:
- Reset (rstN low, async): state=IDLE, all counters 0, agSel=11, all other outputs 0. Reset mid-pass aborts immediately with no write.
- FSM states: IDLE, LOAD, FETCH_Y, FETCH_X, DRAIN, WRITE_Z, CHECK, FIN.
- IDLE: start=1 → LOAD and clear errFlag. start in any other state is ignored.
- LOAD: agLd=1, agSel=11, macClr=1 for one cycle → FETCH_Y.
- FETCH_Y: agSel=01 and memRd=1 while memReady=1. filtCnt increments on each accepted read.
  - After FILT_LEN accepted reads → FETCH_X.
  - filtLd = registered (state==FETCH_Y && memReady).
- FETCH_X: agSel=00 and memRd=1 while memReady=1. winCnt increments on each accepted read.
  - After WIN_LEN accepted reads → DRAIN.
  - macEn = registered (state==FETCH_X && memReady).
- DRAIN: one cycle, agSel=11; lets the final macEn fire → WRITE_Z.
- WRITE_Z: agSel=10 and memWr=1 while memReady=1. Holds until accepted; outCnt increments on acceptance → CHECK.
- CHECK: one cycle, agSel=11.
  - doneAdr=1 → FIN.
  - else outCnt==MAX_OUT → FIN with errFlag=1.
  - else agRstX=1, macClr=1, winCnt=0 → FETCH_X.
  - doneAdr has priority over MAX_OUT when both hold (errFlag stays 0).
- FIN: done=1 for one cycle → IDLE.
- Stall rule: memReady=0 in FETCH_Y, FETCH_X or WRITE_Z holds state and counters, forces agSel=11, and deasserts memRd/memWr. The address generator therefore never advances on a refused access.
- agSel is 11 in all states not listed above, so the address generator never advances outside an accepted access.
- Latency with no stalls, from start sampled at cycle 0:
  - LOAD at cycle 1; FETCH_Y cycles 2-5; FETCH_X cycles 6-21; DRAIN 22; WRITE_Z 23; CHECK 24.
  - Each following window takes 19 cycles.
- Counter widths are $clog2(limit+1); counters never wrap within a pass.

Decomposition:
- Shared package cnn_pkg:
  - SEL_X=2'b00, SEL_Y=2'b01, SEL_Z=2'b10, SEL_IDLE=2'b11
  - state encoding typedef
  - default FILT_LEN, WIN_LEN, MAX_OUT
- One natural sub-module: seq_counter. A loadable, clearable up-counter with enable and a terminal-count flag, instantiated for filtCnt, winCnt and outCnt.

Test Plan:
- Reset mid-FETCH_X (drop rstN at cycle 10) → all outputs at reset values immediately, agSel=11, no memWr. After release, start re-runs from LOAD.
- Single window, memReady=1, doneAdr driven high from cycle 20 → 4 filtLd pulses (cycles 3-6), 16 macEn pulses (cycles 7-22), memWr at cycle 23, done at cycle 25.
- Stalls: memReady low on alternate cycles → agSel=11 and memRd=0 on every low cycle. Exactly 4 y-reads, 16 x-reads and 1 write per window.
- Three windows, doneAdr raised during the third WRITE_Z → agRstX pulses at the first two CHECKs only, 3 memWr, done once.
- MAX_OUT=2, doneAdr held 0 → FIN after the second write with errFlag=1. The next start clears errFlag.
- start pulsed while busy → ignored; pass timing unchanged.
